if_fetch_ctrl: RTL



---
 rtl/if_pkg.sv | 14 +
 rtl/if_fetch_timeout.sv | 40 ++++
 rtl/if_fetch_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and
// timeout counter width.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } if_state_e;

    localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/if_fetch_timeout.sv
// Fetch watchdog: counts consecutive un-acknowledged request cycles and pulses
// o_err for one cycle each time TIMEOUT_CYCLES is reached, then restarts.
module if_fetch_timeout
    import if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_count_en,
    output logic o_err
);

    localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

    logic [TO_CNT_W-1:0] r_cnt;
    logic [TO_CNT_W-1:0] w_cnt_inc;
    logic                w_hit;
    logic                r_err;

    assign w_cnt_inc = r_cnt + TO_CNT_W'(1);
    assign w_hit     = i_count_en && (w_cnt_inc == LIMIT);
    assign o_err     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_hit;
            // Any cycle without counting (ack or no request) reloads zero.
            if (!i_count_en || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: drives the imem handshake at the current PC, buffers
// the fetched word for ID and defers branch/exception redirects to safe points.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_pc_addr,
    output logic        o_pc_enable,
    output logic        o_do_branch,
    output logic [31:0] o_branch_addr,
    output logic        o_do_exception,
    output logic [31:0] o_exception_addr,
    output logic        o_fetch_req,
    output logic [31:0] o_fetch_addr,
    input  logic        i_fetch_ack,
    input  logic [31:0] i_fetch_data,
    input  logic        i_stall_in,
    input  logic        i_branch_req,
    input  logic [31:0] i_branch_target,
    input  logic        i_exc_req,
    input  logic [31:0] i_exc_target,
    output logic        o_inst_valid,
    output logic [31:0] o_inst_out,
    output logic [31:0] o_inst_pc,
    output logic        o_fetch_err
);

    if_state_e   r_state;
    if_state_e   w_state_d;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;
    logic        r_exc_pend;
    logic [31:0] r_exc_tgt;
    logic        r_inst_valid;
    logic [31:0] r_inst_out;
    logic [31:0] r_inst_pc;

    logic        w_exc_now;
    logic [31:0] w_exc_tgt;
    logic        w_br_now;
    logic [31:0] w_br_tgt;
    logic        w_req_state;
    logic        w_deliver;
    logic        w_do_branch;
    logic        w_do_exc;

    // A same-cycle request takes precedence over (and overwrites) the latched one.
    assign w_exc_now   = i_exc_req || r_exc_pend;
    assign w_exc_tgt   = i_exc_req ? i_exc_target : r_exc_tgt;
    assign w_br_now    = i_branch_req || r_br_pend;
    assign w_br_tgt    = i_branch_req ? i_branch_target : r_br_tgt;
    assign w_req_state = (r_state == FETCH) || (r_state == DRAIN);

    always_comb begin
        w_state_d   = r_state;
        w_deliver   = 1'b0;
        w_do_branch = 1'b0;
        w_do_exc    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_d = FETCH;
                w_do_exc  = w_exc_now;
            end
            FETCH: begin
                if (i_fetch_ack) begin
                    if (w_exc_now) begin
                        w_do_exc  = 1'b1;
                        w_state_d = FETCH;
                    end else begin
                        // The acked word is the delay slot when a branch is pending.
                        w_deliver   = 1'b1;
                        w_do_branch = w_br_now;
                        w_state_d   = i_stall_in ? HOLD : FETCH;
                    end
                end else if (w_exc_now) begin
                    w_state_d = DRAIN;
                end
            end
            HOLD: begin
                if (w_exc_now) begin
                    w_do_exc  = 1'b1;
                    w_state_d = FETCH;
                end else if (!i_stall_in) begin
                    w_state_d = FETCH;
                end
            end
            DRAIN: begin
                if (i_fetch_ack) begin
                    w_do_exc  = 1'b1;
                    w_state_d = FETCH;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_br_pend    <= 1'b0;
            r_br_tgt     <= '0;
            r_exc_pend   <= 1'b0;
            r_exc_tgt    <= '0;
            r_inst_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_pc    <= '0;
        end else begin
            r_state <= w_state_d;

            if (w_do_exc) begin
                r_exc_pend <= 1'b0;
            end else if (i_exc_req) begin
                r_exc_pend <= 1'b1;
                r_exc_tgt  <= i_exc_target;
            end

            // An exception in flight drops any branch.
            if (w_exc_now || w_do_branch) begin
                r_br_pend <= 1'b0;
            end else if (i_branch_req) begin
                r_br_pend <= 1'b1;
                r_br_tgt  <= i_branch_target;
            end

            if (w_do_exc) begin
                r_inst_valid <= 1'b0;
            end else if (w_deliver) begin
                r_inst_valid <= 1'b1;
                r_inst_out   <= i_fetch_data;
                r_inst_pc    <= i_pc_addr;
            end else if (r_inst_valid && !i_stall_in) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    if_fetch_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_count_en(w_req_state && !i_fetch_ack),
        .o_err     (o_fetch_err)
    );

    assign o_fetch_req      = w_req_state;
    assign o_fetch_addr     = i_pc_addr;
    assign o_pc_enable      = w_deliver;
    assign o_do_branch      = w_do_branch;
    assign o_branch_addr    = w_do_branch ? w_br_tgt : 32'h0;
    assign o_do_exception   = w_do_exc;
    assign o_exception_addr = w_do_exc ? w_exc_tgt : 32'h0;
    assign o_inst_valid     = r_inst_valid;
    assign o_inst_out       = r_inst_out;
    assign o_inst_pc        = r_inst_pc;

endmodule
